iic_req_arbiter: RTL

IIC_REQ_ARBITER -- requirements
Module: iic_req_arbiter

---
 rtl/iic_arb_pkg.sv | 19 +
 rtl/iic_rr_pick.sv | 31 +++
 rtl/iic_req_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/iic_arb_pkg.sv
// rtl/iic_arb_pkg.sv - shared state encoding, status codes and timing constants for the IIC request arbiter
package iic_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } arb_state_e;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_BUS     = 2'b01;
    localparam logic [1:0] ERR_NO_BUSY = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int BUSY_RISE_TMO = 16;

endpackage

// File: rtl/iic_rr_pick.sv
// rtl/iic_rr_pick.sv - combinational round-robin picker: first set request at or after the pointer, wrapping
module iic_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int c;

    // Scan from farthest to nearest so the nearest candidate is the last (winning) assignment.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        c       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = int'(ptr_i) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (c == j && req_i[j]) begin
                    idx_o   = IDX_W'(j);
                    valid_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/iic_req_arbiter.sv
// rtl/iic_req_arbiter.sv - round-robin arbiter sharing one IIC master among NUM_REQ register-access requesters
module iic_req_arbiter
    import iic_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   wrrd_i,
    input  logic [NUM_REQ*7-1:0] dev_addr_i,
    input  logic [NUM_REQ*8-1:0] reg_addr_i,
    input  logic [NUM_REQ*8-1:0] wr_data_i,
    output logic [NUM_REQ-1:0]   gnt_o,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [7:0]           rd_data_o,
    output logic [1:0]           err_o,
    output logic                 iic_wr_o,
    output logic                 iic_rd_o,
    output logic [6:0]           iic_dev_addr_o,
    output logic [7:0]           iic_reg_addr_o,
    output logic [7:0]           iic_pdata_o,
    input  logic                 iic_busy_i,
    input  logic                 iic_err_i,
    input  logic [7:0]           iic_rd_data_i
);

    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYC > BUSY_RISE_TMO) ? TIMEOUT_CYC : BUSY_RISE_TMO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic               wrrd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic [7:0]         rd_data_q;
    logic [1:0]         err_q;
    logic               iic_wr_q;
    logic               iic_rd_q;
    logic [6:0]         dev_q;
    logic [7:0]         reg_q;
    logic [7:0]         pdata_q;
    logic [IDX_W-1:0]   rr_ptr_d;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               pick_wrrd;
    logic [6:0]         pick_dev;
    logic [7:0]         pick_reg;
    logic [7:0]         pick_wd;

    iic_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        pick_wrrd = 1'b0;
        pick_dev  = '0;
        pick_reg  = '0;
        pick_wd   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_wrrd = wrrd_i[i];
                pick_dev  = dev_addr_i[i*7 +: 7];
                pick_reg  = reg_addr_i[i*8 +: 8];
                pick_wd   = wr_data_i[i*8 +: 8];
            end
        end
    end

    // Saturating so a stuck bus can never wrap the counter back into range.
    assign cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign rr_ptr_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rr_ptr_q  <= '0;
            wrrd_q    <= 1'b0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rd_data_q <= '0;
            err_q     <= ERR_OK;
            iic_wr_q  <= 1'b0;
            iic_rd_q  <= 1'b0;
            dev_q     <= '0;
            reg_q     <= '0;
            pdata_q   <= '0;
        end else begin
            iic_wr_q <= 1'b0;
            iic_rd_q <= 1'b0;
            done_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    // Hold off while the master is busy so a transaction left over from reset drains first.
                    if (!iic_busy_i && pick_valid) begin
                        idx_q   <= pick_idx;
                        wrrd_q  <= pick_wrrd;
                        dev_q   <= pick_dev;
                        reg_q   <= pick_reg;
                        pdata_q <= pick_wd;
                        gnt_q   <= NUM_REQ'(1'b1) << pick_idx;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    iic_wr_q <= !wrrd_q;
                    iic_rd_q <= wrrd_q;
                    cnt_q    <= '0;
                    state_q  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (iic_busy_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_DONE;
                    end else if (cnt_q >= CNT_W'(BUSY_RISE_TMO - 1)) begin
                        cnt_q   <= '0;
                        err_q   <= ERR_NO_BUSY;
                        done_q  <= gnt_q;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!iic_busy_i) begin
                        cnt_q  <= '0;
                        err_q  <= {1'b0, iic_err_i};
                        done_q <= gnt_q;
                        if (wrrd_q) rd_data_q <= iic_rd_data_i;
                        state_q <= ST_RESP;
                    end else if (cnt_q >= CNT_W'(TIMEOUT_CYC - 1)) begin
                        cnt_q   <= '0;
                        err_q   <= ERR_TIMEOUT;
                        done_q  <= gnt_q;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_RESP: begin
                    cnt_q    <= '0;
                    gnt_q    <= '0;
                    rr_ptr_q <= rr_ptr_d;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o          = gnt_q;
    assign done_o         = done_q;
    assign rd_data_o      = rd_data_q;
    assign err_o          = err_q;
    assign iic_wr_o       = iic_wr_q;
    assign iic_rd_o       = iic_rd_q;
    assign iic_dev_addr_o = dev_q;
    assign iic_reg_addr_o = reg_q;
    assign iic_pdata_o    = pdata_q;

endmodule
